core_ctrl_fsm: RTL and testbench
================================

Name: core_ctrl_fsm

Overview:
Second-generation CPU control state machine. It sequences fetch, decode, execute, memory and writeback for one in-order core. Additions over the first-generation FSM:
- parametrised memory-wait watchdog
- latched fault-cause reporting with explicit clear
- single-step mode
- retired-instruction counter

It sits between the decoder/memory interface and the datapath enables.

Parameters:
MEM_TIMEOUT, 256, consecutive wait cycles before a timeout fault; 0 disables the watchdog
CNT_W, 32, width of retired_count
STATE_W, 5, width of current_state

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
go  in  1  start/resume; only the rising edge acts (go & ~go_q)
step_mode  in  1  1 = pause after every retired instruction
fault_clear  in  1  leave FAULT, return to IDLE
halt  in  1  decoded halt (valid in DECODE)
instr_alu  in  1  decoded ALU op
instr_pc  in  1  decoded branch/jump op
ld  in  1  decoded load
st  in  1  decoded store
invalid_instruction  in  1  decoder reject
wait_instr  in  1  1 = instruction memory not ready
wait_data  in  1  1 = data memory not ready
instr_segv  in  1  fetch address fault
data_segv  in  1  data address fault
current_state  out  STATE_W  state encoding
fetch_req  out  1  instruction fetch request
data_req  out  1  data access request
data_we  out  1  data access is a store
alu_en  out  1  ALU execute enable
pc_en  out  1  PC update enable
wb_en  out  1  register writeback enable
running  out  1  core actively executing
fault  out  1  in FAULT
fault_cause  out  3  0 none, 1 IFETCH_SEGV, 2 DATA_SEGV, 3 IFETCH_TIMEOUT, 4 DATA_TIMEOUT, 5 ILLEGAL
retired_count  out  CNT_W  retired instructions, wraps

Behaviour:
- States and encodings: IDLE=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC_ALU=4, EXEC_PC=5, MEM=6, MEM_WAIT=7, WB=8, STEP_PAUSE=9, HALTED=10, FAULT=11.
- Reset (rst=1 at a clk edge, from any state, including mid-wait): state=IDLE, fault_cause=0, retired_count=0, timer=0, go_q=0, is_store_q=0.
- Moore outputs decoded from the state register:
  - fetch_req=FETCH
  - data_req=MEM
  - data_we=MEM & is_store_q
  - alu_en=EXEC_ALU
  - pc_en=EXEC_PC
  - wb_en=WB
  - fault=FAULT
  - running = state not in {IDLE, STEP_PAUSE, HALTED, FAULT}
- IDLE: go edge -> FETCH.
- FETCH -> FETCH_WAIT; timer cleared.
- FETCH_WAIT, priority order:
  1. instr_segv -> FAULT, cause 1
  2. !wait_instr -> DECODE
  3. MEM_TIMEOUT!=0 and timer==MEM_TIMEOUT-1 -> FAULT, cause 3
  4. otherwise timer++
  - Timeout therefore lands on the MEM_TIMEOUT-th consecutive wait cycle.
- DECODE, priority order:
  1. invalid_instruction -> FAULT, cause 5
  2. more than one of {instr_alu, instr_pc, ld|st} set, or ld&st -> FAULT, cause 5
  3. halt -> HALTED (counts as retired)
  4. ld|st -> MEM; is_store_q<=st
  5. instr_pc -> EXEC_PC
  6. instr_alu -> EXEC_ALU
  7. none set -> FAULT, cause 5
- EXEC_ALU -> WB.
- EXEC_PC -> retire.
- MEM -> MEM_WAIT; timer cleared.
- MEM_WAIT: same priority as FETCH_WAIT.
  - data_segv -> cause 2.
  - Ready: load -> WB; store -> retire.
  - Timeout -> cause 4.
- WB -> retire.
- Retire: retired_count += 1 (modulo 2^CNT_W); next state = step_mode ? STEP_PAUSE : FETCH.
- STEP_PAUSE and HALTED: go edge -> FETCH. A held-high go never re-triggers.
- FAULT is sticky; fault_cause holds.
  - fault_clear -> IDLE, cause 0.
  - rst overrides fault_clear.
  - retired_count is preserved across fault_clear.
- Latency with zero memory wait: ALU 5 cycles, load 6, store 5, PC 4, fetch-to-fetch.

Decomposition:
- Package core_ctrl_pkg: state encoding localparams and fault cause codes. Shared with the datapath and benches.
- One sub-module, wait_timer. It is a counter with clear, enable and an expired flag, compared against MEM_TIMEOUT, and is used by both wait states.

Test Plan:
1. rst, go pulse, instr_alu=1, wait_instr=wait_data=0 -> fetch_req at FETCH, alu_en, wb_en. After 5 cycles state=FETCH and retired_count=1.
2. step_mode=1 with go held 1 after the first edge -> state stays STEP_PAUSE (9). Drop go, pulse again -> FETCH, second retire gives count=2.
3. MEM_TIMEOUT=4, load, wait_data held 1 -> FAULT after exactly 4 MEM_WAIT cycles, fault_cause=4. fault_clear -> IDLE, cause=0, count unchanged.
4. In FETCH_WAIT, instr_segv=1 and wait_instr=0 in the same cycle -> FAULT, cause=1 (segv beats ready).
5. DECODE with ld=st=1 -> FAULT, cause=5. Separately, halt=1 -> HALTED with count incremented; go pulse -> FETCH.
6. Store with wait_data=1 for 3 cycles, then rst in MEM_WAIT -> next state IDLE, retired_count=0, data_req=0.

Source files
------------

// File: rtl/core_ctrl_fsm_pkg.sv
// Shared encodings for the core control FSM: state codes and latched fault causes.
// Imported by the controller, the datapath and the benches.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC_ALU   = 4'd4,
    S_EXEC_PC    = 4'd5,
    S_MEM        = 4'd6,
    S_MEM_WAIT   = 4'd7,
    S_WB         = 4'd8,
    S_STEP_PAUSE = 4'd9,
    S_HALTED     = 4'd10,
    S_FAULT      = 4'd11
  } state_e;

  localparam logic [2:0] CAUSE_NONE           = 3'd0;
  localparam logic [2:0] CAUSE_IFETCH_SEGV    = 3'd1;
  localparam logic [2:0] CAUSE_DATA_SEGV      = 3'd2;
  localparam logic [2:0] CAUSE_IFETCH_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_DATA_TIMEOUT   = 3'd4;
  localparam logic [2:0] CAUSE_ILLEGAL        = 3'd5;

endpackage

// File: rtl/core_ctrl_fsm_wait_timer.sv
// Memory-wait watchdog counter shared by FETCH_WAIT and MEM_WAIT.
// expired is high on the TIMEOUT-th consecutive enabled cycle; TIMEOUT=0 never expires.
module wait_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == W'(LIM));

endmodule

// File: rtl/core_ctrl_fsm.sv
// In-order core control FSM: fetch/decode/execute/mem/writeback sequencing with
// memory-wait watchdog, sticky fault cause, single-step pause and retire counter.
module core_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STATE_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               step_mode,
  input  logic               fault_clear,
  input  logic               halt,
  input  logic               instr_alu,
  input  logic               instr_pc,
  input  logic               ld,
  input  logic               st,
  input  logic               invalid_instruction,
  input  logic               wait_instr,
  input  logic               wait_data,
  input  logic               instr_segv,
  input  logic               data_segv,
  output logic [STATE_W-1:0] current_state,
  output logic               fetch_req,
  output logic               data_req,
  output logic               data_we,
  output logic               alu_en,
  output logic               pc_en,
  output logic               wb_en,
  output logic               running,
  output logic               fault,
  output logic [2:0]         fault_cause,
  output logic [CNT_W-1:0]   retired_count
);
  state_e           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_q, is_store_q, store_d;
  logic             go_rise, retire, multi_op, tmr_exp;
  state_e           after_retire;

  assign go_rise      = go & ~go_q;
  assign after_retire = step_mode ? S_STEP_PAUSE : S_FETCH;
  assign multi_op     = (instr_alu & instr_pc) | (instr_alu & (ld | st)) |
                        (instr_pc & (ld | st)) | (ld & st);

  wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == S_FETCH) || (state_q == S_MEM)),
    .en      ((state_q == S_FETCH_WAIT) || (state_q == S_MEM_WAIT)),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    store_d = is_store_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:       if (go_rise) state_d = S_FETCH;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (instr_segv) begin
          state_d = S_FAULT; cause_d = CAUSE_IFETCH_SEGV;
        end else if (!wait_instr) begin
          state_d = S_DECODE;
        end else if (tmr_exp) begin
          state_d = S_FAULT; cause_d = CAUSE_IFETCH_TIMEOUT;
        end
      end
      S_DECODE: begin
        // Halt retires in place, so it ranks below the illegal checks but above dispatch.
        if (invalid_instruction || multi_op) begin
          state_d = S_FAULT; cause_d = CAUSE_ILLEGAL;
        end else if (halt) begin
          state_d = S_HALTED; retire = 1'b1;
        end else if (ld || st) begin
          state_d = S_MEM; store_d = st;
        end else if (instr_pc) begin
          state_d = S_EXEC_PC;
        end else if (instr_alu) begin
          state_d = S_EXEC_ALU;
        end else begin
          state_d = S_FAULT; cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC_ALU:   state_d = S_WB;
      S_EXEC_PC:    begin state_d = after_retire; retire = 1'b1; end
      S_MEM:        state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (data_segv) begin
          state_d = S_FAULT; cause_d = CAUSE_DATA_SEGV;
        end else if (!wait_data) begin
          if (is_store_q) begin state_d = after_retire; retire = 1'b1; end
          else            state_d = S_WB;
        end else if (tmr_exp) begin
          state_d = S_FAULT; cause_d = CAUSE_DATA_TIMEOUT;
        end
      end
      S_WB:         begin state_d = after_retire; retire = 1'b1; end
      S_STEP_PAUSE,
      S_HALTED:     if (go_rise) state_d = S_FETCH;
      S_FAULT: begin
        if (fault_clear) begin
          state_d = S_IDLE; cause_d = CAUSE_NONE;
        end
      end
      default:      state_d = S_IDLE;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cause_q    <= CAUSE_NONE;
      cnt_q      <= '0;
      go_q       <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      go_q       <= go;
      is_store_q <= store_d;
    end
  end

  assign current_state = STATE_W'(state_q);
  assign fetch_req     = (state_q == S_FETCH);
  assign data_req      = (state_q == S_MEM);
  assign data_we       = (state_q == S_MEM) & is_store_q;
  assign alu_en        = (state_q == S_EXEC_ALU);
  assign pc_en         = (state_q == S_EXEC_PC);
  assign wb_en         = (state_q == S_WB);
  assign fault         = (state_q == S_FAULT);
  assign running       = !((state_q == S_IDLE) || (state_q == S_STEP_PAUSE) ||
                           (state_q == S_HALTED) || (state_q == S_FAULT));
  assign fault_cause   = cause_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: per-instruction scenarios are expanded into an expected
// cycle schedule (state, outputs, cause, count) plus the stimulus for each cycle.
module tb_core_ctrl_fsm;
  localparam int TO = 4;
  localparam int CW = 6;

  localparam logic [4:0] IDLE = 0, FETCH = 1, FW = 2, DECODE = 3, EALU = 4, EPC = 5,
                         MEM = 6, MW = 7, WB = 8, PAUSE = 9, HALTED = 10, FAULT = 11;
  localparam int K_ALU = 0, K_PC = 1, K_LD = 2, K_ST = 3, K_HALT = 4, K_ILL = 5,
                 K_ISEGV = 6, K_DSEGV = 7, K_ITO = 8, K_DTO = 9, K_RST = 10;

  typedef struct packed {
    logic rst, go, step, fclr, halt, alu, pc, ld, st, inv, wi, wd, isegv, dsegv;
  } inp_t;
  typedef struct packed {
    logic [4:0] st; logic we; logic [2:0] cause; logic [CW-1:0] cnt; inp_t in;
  } ent_t;

  logic clk = 1'b0;
  logic rst, go, step_mode, fault_clear, halt, instr_alu, instr_pc, ld, st;
  logic invalid_instruction, wait_instr, wait_data, instr_segv, data_segv;
  logic [4:0] current_state;
  logic fetch_req, data_req, data_we, alu_en, pc_en, wb_en, running, fault;
  logic [2:0] fault_cause;
  logic [CW-1:0] retired_count;

  ent_t q[$];
  logic [CW-1:0] mcnt;
  logic [2:0] mcause;
  logic mstore;
  int pass_n = 0, tot_n = 0;

  always #5 clk = ~clk;

  core_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW), .STATE_W(5)) dut (
    .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .fault_clear(fault_clear),
    .halt(halt), .instr_alu(instr_alu), .instr_pc(instr_pc), .ld(ld), .st(st),
    .invalid_instruction(invalid_instruction), .wait_instr(wait_instr),
    .wait_data(wait_data), .instr_segv(instr_segv), .data_segv(data_segv),
    .current_state(current_state), .fetch_req(fetch_req), .data_req(data_req),
    .data_we(data_we), .alu_en(alu_en), .pc_en(pc_en), .wb_en(wb_en),
    .running(running), .fault(fault), .fault_cause(fault_cause),
    .retired_count(retired_count));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_outs(logic [4:0] s, logic we);
    logic run;
    run = !(s == IDLE || s == PAUSE || s == HALTED || s == FAULT);
    return {s == FETCH, s == MEM, we, s == EALU, s == EPC, s == WB, run, s == FAULT};
  endfunction

  // Random values on every input except reset; callers pin what matters.
  function automatic inp_t noise();
    inp_t n;
    n = inp_t'(14'($urandom));
    n.rst = 1'b0;
    return n;
  endfunction

  task automatic push(logic [4:0] s, inp_t in);
    ent_t e;
    e.st = s; e.we = (s == MEM) && mstore; e.cause = mcause; e.cnt = mcnt; e.in = in;
    q.push_back(e);
  endtask

  task automatic idle_go(logic [4:0] s);
    inp_t i;
    int n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) begin i = noise(); i.go = 1'b0; push(s, i); end
    i = noise(); i.go = 1'b1; push(s, i);
  endtask

  task automatic fault_seq();
    inp_t i;
    int n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) begin i = noise(); i.fclr = 1'b0; push(FAULT, i); end
    i = noise(); i.fclr = 1'b1;
    if ($urandom_range(0, 7) == 0) begin
      i.rst = 1'b1; push(FAULT, i); mcnt = '0; mstore = 1'b0;
    end else push(FAULT, i);
    mcause = 3'd0;
    idle_go(IDLE);
  endtask

  task automatic retire_entry(logic [4:0] s, inp_t in, bit step, bit hold_go);
    inp_t i;
    in.step = step; in.go = hold_go;
    push(s, in);
    mcnt++;
    if (step) begin
      int n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin i = noise(); i.go = hold_go; push(PAUSE, i); end
      idle_go(PAUSE);
    end
  endtask

  task automatic instr(int kind, int fw, int dw, bit step, bit hold_go);
    inp_t i;
    int v;
    push(FETCH, noise());
    if (kind == K_ITO) begin
      for (int k = 0; k < TO; k++) begin
        i = noise(); i.wi = 1'b1; i.isegv = 1'b0; push(FW, i);
      end
      mcause = 3'd3; fault_seq(); return;
    end
    for (int k = 0; k < fw; k++) begin
      i = noise(); i.wi = 1'b1; i.isegv = 1'b0; push(FW, i);
    end
    i = noise(); i.wi = 1'b0; i.isegv = (kind == K_ISEGV); push(FW, i);
    if (kind == K_ISEGV) begin mcause = 3'd1; fault_seq(); return; end

    i = noise();
    {i.inv, i.halt, i.alu, i.pc, i.ld, i.st} = '0;
    case (kind)
      K_ALU: i.alu = 1'b1;
      K_PC:  i.pc  = 1'b1;
      K_LD:  i.ld  = 1'b1;
      K_ST:  i.st  = 1'b1;
      K_DSEGV, K_DTO, K_RST: if ($urandom_range(0, 1) == 1) i.st = 1'b1; else i.ld = 1'b1;
      K_HALT: begin
        i.halt = 1'b1;
        v = $urandom_range(0, 4);
        i.alu = (v == 0); i.pc = (v == 1); i.ld = (v == 2); i.st = (v == 3);
      end
      default: begin
        v = $urandom_range(0, 3);
        if (v == 0) begin
          {i.halt, i.alu, i.pc, i.ld, i.st} = 5'($urandom); i.inv = 1'b1;
        end else if (v == 1) begin
          i.ld = 1'b1; i.st = 1'b1; {i.halt, i.alu, i.pc} = 3'($urandom);
        end else if (v == 2) begin
          i.halt = 1'($urandom);
          case ($urandom_range(0, 2))
            0: begin i.alu = 1'b1; i.pc = 1'b1; end
            1: begin i.alu = 1'b1; i.ld = 1'b1; end
            default: begin i.pc = 1'b1; i.st = 1'b1; end
          endcase
        end
      end
    endcase
    push(DECODE, i);
    case (kind)
      K_ILL:  begin mcause = 3'd5; fault_seq(); end
      K_HALT: begin mcnt++; idle_go(HALTED); end
      K_ALU:  begin push(EALU, noise()); retire_entry(WB, noise(), step, hold_go); end
      K_PC:   retire_entry(EPC, noise(), step, hold_go);
      default: begin
        mstore = i.st;
        push(MEM, noise());
        if (kind == K_DTO) begin
          for (int k = 0; k < TO; k++) begin
            i = noise(); i.wd = 1'b1; i.dsegv = 1'b0; push(MW, i);
          end
          mcause = 3'd4; fault_seq(); return;
        end
        for (int k = 0; k < dw; k++) begin
          i = noise(); i.wd = 1'b1; i.dsegv = 1'b0; push(MW, i);
        end
        i = noise();
        if (kind == K_DSEGV) begin
          i.dsegv = 1'b1; i.wd = 1'b0; push(MW, i); mcause = 3'd2; fault_seq();
        end else if (kind == K_RST) begin
          i.wd = 1'b1; i.rst = 1'b1; push(MW, i);
          mcnt = '0; mcause = 3'd0; mstore = 1'b0;
          idle_go(IDLE);
        end else begin
          i.wd = 1'b0; i.dsegv = 1'b0;
          if (mstore) retire_entry(MW, i, step, hold_go);
          else begin push(MW, i); retire_entry(WB, noise(), step, hold_go); end
        end
      end
    endcase
  endtask

  function automatic int pick_kind();
    int r = $urandom_range(0, 99);
    if (r < 25) return K_ALU;
    if (r < 40) return K_PC;
    if (r < 55) return K_LD;
    if (r < 68) return K_ST;
    if (r < 73) return K_HALT;
    if (r < 80) return K_ILL;
    if (r < 84) return K_ISEGV;
    if (r < 88) return K_DSEGV;
    if (r < 92) return K_ITO;
    if (r < 97) return K_DTO;
    return K_RST;
  endfunction

  initial begin
    ent_t e;
    {rst, go, step_mode, fault_clear, halt, instr_alu, instr_pc, ld, st} = '0;
    {invalid_instruction, wait_instr, wait_data, instr_segv, data_segv} = '0;
    rst = 1'b1;
    mcnt = '0; mcause = 3'd0; mstore = 1'b0;

    idle_go(IDLE);
    instr(K_ALU, 0, 0, 1'b0, 1'b0);
    instr(K_ALU, 0, 0, 1'b1, 1'b1);
    instr(K_LD, 0, 0, 1'b0, 1'b0);
    instr(K_ST, 0, TO - 1, 1'b0, 1'b0);
    instr(K_DTO, 0, 0, 1'b0, 1'b0);
    instr(K_ISEGV, 0, 0, 1'b0, 1'b0);
    instr(K_ITO, 0, 0, 1'b0, 1'b0);
    instr(K_PC, TO - 1, 0, 1'b1, 1'b0);
    instr(K_ILL, 0, 0, 1'b0, 1'b0);
    instr(K_HALT, 0, 0, 1'b0, 1'b0);
    instr(K_RST, 0, 3, 1'b0, 1'b0);
    for (int k = 0; k < 70; k++) instr(K_ALU, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++)
      instr(pick_kind(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO - 1) : 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, TO - 1) : 0,
            ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1);

    repeat (2) @(posedge clk);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      e = q[k];
      if (k == 0) rst = 1'b0;
      chk($sformatf("state@%0d", k), 32'(current_state), 32'(e.st));
      chk($sformatf("outs@%0d", k),
          32'({fetch_req, data_req, data_we, alu_en, pc_en, wb_en, running, fault}),
          32'(exp_outs(e.st, e.we)));
      chk($sformatf("cause@%0d", k), 32'(fault_cause), 32'(e.cause));
      chk($sformatf("count@%0d", k), 32'(retired_count), 32'(e.cnt));
      {rst, go, step_mode, fault_clear, halt, instr_alu, instr_pc, ld, st,
       invalid_instruction, wait_instr, wait_data, instr_segv, data_segv} = e.in;
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
